// File: rtl/store_drain_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// store_drain_ctrl_pkg
// Shared sizing constants and types for the committed-store buffer and its
// data-SRAM port scheduler.
//   SB_DEPTH        - store-buffer entries (power of two, >= 2)
//   SB_PTR_W        - log2(SB_DEPTH)
//   SB_STARVE_LIMIT - consecutive load wins allowed before a drain is forced
//   SB_ENTRY_WD     - width of one logical entry {addr, sel, data}
// -----------------------------------------------------------------------------
package store_drain_ctrl_pkg;

  localparam int SB_DEPTH        = 4;
  localparam int SB_PTR_W        = 2;
  localparam int SB_STARVE_LIMIT = 8;
  localparam int SB_ENTRY_WD     = 32 + 4 + 32;

  // The word address lives in the CAM; the rest of the entry ({sel, data}) is
  // the payload kept next to the pointers.
  localparam int SB_PAYLOAD_WD   = SB_ENTRY_WD - 32;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] data;
  } sb_entry_t;

  // Owner of the data-SRAM port in the current cycle.
  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_LOAD   = 2'd1,
    ARB_STORE  = 2'd2,
    ARB_FREEZE = 2'd3
  } arb_e;

endpackage

// File: rtl/store_drain_ctrl_sb_entry_cam.sv
// -----------------------------------------------------------------------------
// sb_entry_cam
// Valid bits and word addresses (addr[31:2]) of the store-buffer entries, plus
// the load-alias compare against them.
// Ports:
//   clk, reset            - clock, async active-high reset (clears valids)
//   i_wr_en/i_wr_idx      - allocate entry at i_wr_idx with word i_wr_waddr
//   i_clr_en/i_clr_idx    - retire entry at i_clr_idx
//   i_rd_idx/o_rd_waddr   - word address of the entry at i_rd_idx (head)
//   i_ld_req/i_ld_waddr   - load probe; o_conflict when it hits a valid entry
// -----------------------------------------------------------------------------
module sb_entry_cam
  import store_drain_ctrl_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int PTR_W = SB_PTR_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_wr_en,
  input  logic [PTR_W-1:0] i_wr_idx,
  input  logic [29:0]      i_wr_waddr,
  input  logic             i_clr_en,
  input  logic [PTR_W-1:0] i_clr_idx,
  input  logic [PTR_W-1:0] i_rd_idx,
  output logic [29:0]      o_rd_waddr,
  input  logic             i_ld_req,
  input  logic [29:0]      i_ld_waddr,
  output logic             o_conflict
);

  logic [DEPTH-1:0] r_valid;
  logic [29:0]      r_waddr [DEPTH];
  logic [DEPTH-1:0] w_hit;

  // Allocation and retirement never target the same slot in one cycle: the
  // tail only equals the head when the buffer is empty (no retire) or full
  // (no allocate).
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
    end else begin
      if (i_clr_en) r_valid[i_clr_idx] <= 1'b0;
      if (i_wr_en)  r_valid[i_wr_idx]  <= 1'b1;
    end
  end

  // NOTE: the address array is deliberately not reset; an entry is only
  // observed through its valid bit, which is reset.
  always_ff @(posedge clk) begin
    if (i_wr_en) r_waddr[i_wr_idx] <= i_wr_waddr;
  end

  // Registered entries only: a store pushed this cycle is not yet visible.
  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_hit[i] = r_valid[i] && (r_waddr[i] == i_ld_waddr);
    end
  end

  assign o_conflict = i_ld_req & (|w_hit);
  assign o_rd_waddr = r_waddr[i_rd_idx];

endmodule

// File: rtl/store_drain_ctrl.sv
// -----------------------------------------------------------------------------
// store_drain_ctrl
// Committed-store buffer that shares the single data-SRAM port between AGU
// loads and store drains. Loads win unless they alias a queued store word or
// the buffer has lost STARVE_LIMIT consecutive cycles to loads.
// Ports:
//   clk, reset                     - clock, async active-high reset
//   st_push/st_addr/st_sel/st_data - retired store from commit
//   st_full, sb_empty, sb_count    - occupancy (registered state only)
//   ld_req/ld_addr                 - AGU load request
//   ld_grant, ld_conflict          - load owns the port / load aliases a store
//   dcache_miss                    - freezes the port
//   data_sram_en/wen/addr/wdata    - SRAM access (wen/wdata are 0 for loads)
// -----------------------------------------------------------------------------
module store_drain_ctrl
  import store_drain_ctrl_pkg::*;
#(
  parameter int DEPTH        = SB_DEPTH,
  parameter int PTR_W        = SB_PTR_W,
  parameter int STARVE_LIMIT = SB_STARVE_LIMIT
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           st_push,
  input  logic [31:0]    st_addr,
  input  logic [3:0]     st_sel,
  input  logic [31:0]    st_data,
  output logic           st_full,
  output logic           sb_empty,
  output logic [PTR_W:0] sb_count,
  input  logic           ld_req,
  input  logic [31:0]    ld_addr,
  output logic           ld_grant,
  output logic           ld_conflict,
  input  logic           dcache_miss,
  output logic           data_sram_en,
  output logic [3:0]     data_sram_wen,
  output logic [31:0]    data_sram_addr,
  output logic [31:0]    data_sram_wdata
);

  localparam logic [PTR_W:0] LP_FULL_COUNT = (PTR_W + 1)'(DEPTH);
  localparam logic [3:0]     LP_STARVE_MAX = 4'(STARVE_LIMIT);

  logic [PTR_W-1:0]         r_head;
  logic [PTR_W-1:0]         r_tail;
  logic [PTR_W:0]           r_count;
  logic [3:0]               r_starve;
  logic [SB_PAYLOAD_WD-1:0] r_payload [DEPTH];

  logic        w_empty;
  logic        w_full;
  logic        w_push;
  logic        w_pop;
  logic        w_conflict;
  logic [29:0] w_head_waddr;
  sb_entry_t   w_head_entry;
  arb_e        w_arb;
  logic        w_unused;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == LP_FULL_COUNT);

  // A push while full is dropped even if a drain frees a slot this cycle.
  assign w_push = st_push & ~w_full;
  assign w_pop  = (w_arb == ARB_STORE);

  // Stores are word-granular; the byte offset is carried by st_sel.
  assign w_unused = ^st_addr[1:0];

  sb_entry_cam #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_cam (
    .clk        (clk),
    .reset      (reset),
    .i_wr_en    (w_push),
    .i_wr_idx   (r_tail),
    .i_wr_waddr (st_addr[31:2]),
    .i_clr_en   (w_pop),
    .i_clr_idx  (r_head),
    .i_rd_idx   (r_head),
    .o_rd_waddr (w_head_waddr),
    .i_ld_req   (ld_req),
    .i_ld_waddr (ld_addr[31:2]),
    .o_conflict (w_conflict)
  );

  assign w_head_entry = {w_head_waddr, 2'b00, r_payload[r_head]};

  // Port arbitration. A conflicting load falls through to a drain, which is
  // what eventually retires the aliasing entry and unblocks the load.
  always_comb begin
    w_arb = ARB_IDLE;
    if (reset) begin
      w_arb = ARB_IDLE;
    end else if (dcache_miss) begin
      w_arb = ARB_FREEZE;
    end else if (ld_req && !w_conflict &&
                 !((r_starve == LP_STARVE_MAX) && !w_empty)) begin
      w_arb = ARB_LOAD;
    end else if (!w_empty) begin
      w_arb = ARB_STORE;
    end
  end

  always_comb begin
    ld_grant        = 1'b0;
    data_sram_en    = 1'b0;
    data_sram_wen   = '0;
    data_sram_addr  = '0;
    data_sram_wdata = '0;
    case (w_arb)
      ARB_LOAD: begin
        ld_grant       = 1'b1;
        data_sram_en   = 1'b1;
        data_sram_addr = ld_addr;
      end
      ARB_STORE: begin
        data_sram_en    = 1'b1;
        data_sram_wen   = w_head_entry.sel;
        data_sram_addr  = w_head_entry.addr;
        data_sram_wdata = w_head_entry.data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      r_starve <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase

      // Counts only loads that beat a waiting store; frozen cycles are neutral.
      if (w_arb != ARB_FREEZE) begin
        if (w_pop || w_empty) begin
          r_starve <= '0;
        end else if ((w_arb == ARB_LOAD) && (r_starve < LP_STARVE_MAX)) begin
          r_starve <= r_starve + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_payload[r_tail] <= {st_sel, st_data};
  end

  assign st_full     = w_full;
  assign sb_empty    = w_empty;
  assign sb_count    = r_count;
  assign ld_conflict = w_conflict;

endmodule

// File: tb/tb_store_drain_ctrl.sv
// -----------------------------------------------------------------------------
// tb_store_drain_ctrl
// Directed stimulus for store_drain_ctrl. Each cycle's expected SRAM access is
// queued when the stimulus is issued; an independent monitor pops and compares
// whenever the DUT enables the SRAM port.
// -----------------------------------------------------------------------------
module tb_store_drain_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_push;
  logic [31:0] st_addr;
  logic [3:0]  st_sel;
  logic [31:0] st_data;
  logic        st_full;
  logic        sb_empty;
  logic [2:0]  sb_count;
  logic        ld_req;
  logic [31:0] ld_addr;
  logic        ld_grant;
  logic        ld_conflict;
  logic        dcache_miss;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;

  always #5 clk = ~clk;

  store_drain_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .st_push         (st_push),
    .st_addr         (st_addr),
    .st_sel          (st_sel),
    .st_data         (st_data),
    .st_full         (st_full),
    .sb_empty        (sb_empty),
    .sb_count        (sb_count),
    .ld_req          (ld_req),
    .ld_addr         (ld_addr),
    .ld_grant        (ld_grant),
    .ld_conflict     (ld_conflict),
    .dcache_miss     (dcache_miss),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata)
  );

  typedef struct packed {
    logic        grant;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
  } acc_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] data;
  } st_t;

  acc_t sb_q[$];     // expected SRAM accesses, in issue order
  st_t  model_q[$];  // stores accepted by the buffer, oldest first

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every enabled SRAM cycle must match the oldest expectation.
  always @(negedge clk) begin
    acc_t e;
    if (data_sram_en === 1'b1) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_access: got addr=0x%0h wen=%b, want no access",
                 data_sram_addr, data_sram_wen);
      end else begin
        e = sb_q.pop_front();
        check("acc_grant", 32'(ld_grant), 32'(e.grant));
        check("acc_wen", 32'(data_sram_wen), 32'(e.wen));
        check("acc_addr", data_sram_addr, e.addr);
        check("acc_wdata", data_sram_wdata, e.wdata);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_st(input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] d);
    st_push = 1'b1;
    st_addr = a;
    st_sel  = s;
    st_data = d;
    model_q.push_back('{addr: a, sel: s, data: d});
  endtask

  task automatic exp_store();
    st_t s;
    s = model_q.pop_front();
    sb_q.push_back('{grant: 1'b0, wen: s.sel, addr: {s.addr[31:2], 2'b00},
                     wdata: s.data});
  endtask

  task automatic exp_load(input logic [31:0] a);
    sb_q.push_back('{grant: 1'b1, wen: 4'b0000, addr: a, wdata: 32'h0});
  endtask

  initial begin
    reset       = 1'b1;
    st_push     = 1'b0;
    st_addr     = '0;
    st_sel      = '0;
    st_data     = '0;
    dcache_miss = 1'b0;
    ld_req      = 1'b1;       // must stay ungranted while reset is high
    ld_addr     = 32'h500;

    @(negedge clk);
    check("rst_grant", 32'(ld_grant), 0);
    check("rst_en", 32'(data_sram_en), 0);
    check("rst_empty", 32'(sb_empty), 1);
    check("rst_count", 32'(sb_count), 0);
    check("rst_full", 32'(st_full), 0);

    cyc();
    reset  = 1'b0;
    ld_req = 1'b0;

    // Basic drain: store appears on the port the cycle after the push.
    cyc();
    push_st(32'h100, 4'b1111, 32'hDEADBEEF);
    @(negedge clk);
    check("t1_count_pre", 32'(sb_count), 0);
    cyc();
    st_push = 1'b0;
    exp_store();
    @(negedge clk);
    check("t1_count", 32'(sb_count), 1);
    check("t1_en", 32'(data_sram_en), 1);
    cyc();
    @(negedge clk);
    check("t1_empty", 32'(sb_empty), 1);
    check("t1_idle_en", 32'(data_sram_en), 0);

    // Load priority over a queued store.
    cyc();
    push_st(32'h180, 4'b1111, 32'h11111111);
    cyc();
    st_push = 1'b0;
    ld_req  = 1'b1;
    ld_addr = 32'h200;
    exp_load(32'h200);
    @(negedge clk);
    check("t2_grant", 32'(ld_grant), 1);
    check("t2_count", 32'(sb_count), 1);
    cyc();
    ld_req = 1'b0;
    exp_store();
    @(negedge clk);
    check("t2_count_drain", 32'(sb_count), 1);
    cyc();
    @(negedge clk);
    check("t2_empty", 32'(sb_empty), 1);

    // Conflict: a same-cycle push is not compared; a queued one blocks.
    cyc();
    push_st(32'h104, 4'b0011, 32'h0000BEEF);
    ld_req  = 1'b1;
    ld_addr = 32'h106;
    exp_load(32'h106);
    @(negedge clk);
    check("t3_same_cycle_conflict", 32'(ld_conflict), 0);
    cyc();
    st_push = 1'b0;
    exp_store();
    @(negedge clk);
    check("t3_conflict", 32'(ld_conflict), 1);
    check("t3_blocked", 32'(ld_grant), 0);
    cyc();
    exp_load(32'h106);
    @(negedge clk);
    check("t3_unblocked_conflict", 32'(ld_conflict), 0);
    check("t3_unblocked_grant", 32'(ld_grant), 1);
    cyc();
    ld_req = 1'b0;

    // Starvation: 8 load wins, then a forced drain; the second round shows
    // the counter restarted from zero after the drain.
    push_st(32'h400, 4'b1111, 32'hCAFEF00D);
    for (int rep = 0; rep < 2; rep++) begin
      for (int k = 0; k < 9; k++) begin
        cyc();
        st_push = 1'b0;
        ld_req  = 1'b1;
        ld_addr = 32'h300;
        if (k < 8) begin
          exp_load(32'h300);
        end else begin
          exp_store();
          if (rep == 0) push_st(32'h404, 4'b1100, 32'h0BADF00D);
        end
        @(negedge clk);
        check("t4_grant", 32'(ld_grant), 32'(k < 8));
      end
    end
    cyc();
    st_push = 1'b0;
    ld_req  = 1'b0;
    @(negedge clk);
    check("t4_empty", 32'(sb_empty), 1);

    // Full / wrap: fill behind a frozen port, reject a push while full, then
    // drain with simultaneous pushes across the pointer wrap.
    for (int i = 0; i < 4; i++) begin
      cyc();
      dcache_miss = 1'b1;
      push_st(32'h1000 + 32'(4 * i), 4'(i + 1), 32'hA0000000 + 32'(i));
      @(negedge clk);
      check("t5_fill_en", 32'(data_sram_en), 0);
    end
    cyc();
    st_push = 1'b1;               // must be dropped: buffer is full
    st_addr = 32'h1010;
    st_sel  = 4'b1111;
    st_data = 32'hEEEEEEEE;
    @(negedge clk);
    check("t5_full", 32'(st_full), 1);
    check("t5_count_full", 32'(sb_count), 4);
    cyc();
    st_push = 1'b0;
    @(negedge clk);
    check("t5_push_ignored", 32'(sb_count), 4);
    cyc();
    dcache_miss = 1'b0;
    exp_store();
    @(negedge clk);
    check("t5_count_first_pop", 32'(sb_count), 4);
    for (int c = 0; c < 10; c++) begin
      cyc();
      if (c == 4 || c == 5) begin
        dcache_miss = 1'b1;
        st_push     = 1'b0;
      end else begin
        dcache_miss = 1'b0;
        push_st(32'h2000 + 32'(4 * c), 4'(c + 1), 32'hB0000000 + 32'(c));
        exp_store();
      end
      @(negedge clk);
      check("t5_count_steady", 32'(sb_count), 3);
      if (c == 4 || c == 5) check("t5_miss_en", 32'(data_sram_en), 0);
    end
    for (int i = 0; i < 3; i++) begin
      cyc();
      st_push     = 1'b0;
      dcache_miss = 1'b0;
      exp_store();
    end
    cyc();
    @(negedge clk);
    check("t5_empty", 32'(sb_empty), 1);

    // Reset during the first drain cycle discards everything queued.
    for (int i = 0; i < 3; i++) begin
      cyc();
      dcache_miss = 1'b1;
      push_st(32'h3000 + 32'(4 * i), 4'b1111, 32'hC0 + 32'(i));
    end
    cyc();
    st_push     = 1'b0;
    dcache_miss = 1'b0;
    reset       = 1'b1;
    model_q.delete();
    @(negedge clk);
    check("t6_rst_en", 32'(data_sram_en), 0);
    check("t6_rst_empty", 32'(sb_empty), 1);
    check("t6_rst_count", 32'(sb_count), 0);
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t6_post_en", 32'(data_sram_en), 0);
      check("t6_post_count", 32'(sb_count), 0);
      cyc();
    end

    @(negedge clk);
    check("sb_drained", 32'(sb_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
